// File: rtl/rsa_4k_pkg.sv
// Shared definitions for the rsa_4k modular-exponentiation engine:
// default operand width, FSM states and the fixed job latency.
package rsa_4k_pkg;

  localparam int DEFAULT_WIDTH = 4096;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    EXP,
    POST,
    DONE
  } state_e;

  // Cycles from the go-capture edge to the edge that raises done.
  function automatic int latency_cycles(input int width);
    return width + 2 * width * (width + 1) + (width + 1) + 1;
  endfunction

endpackage

// File: rtl/rsa_4k_montmul.sv
// Bit-serial radix-2 Montgomery multiplier: result = x*y*2^-WIDTH mod n.
// Operands are captured on start; ready pulses once WIDTH+1 edges later.
module rsa_4k_montmul
  import rsa_4k_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH+1:0] s_q, s_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] n_ext;

  always_comb begin
    s_d     = s_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    n_ext   = {2'b00, n};
    sum     = s_q + (x_q[0] ? {2'b00, y_q} : '0);
    if (sum[0]) begin
      sum = sum + n_ext;
    end
    if (start) begin
      s_d    = '0;
      x_d    = x;
      y_d    = y;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      s_d   = sum >> 1;
      x_d   = x_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    end
  end

  // The loop leaves s below 2n, so one conditional subtract finishes the reduction.
  always_comb begin
    result = WIDTH'((s_q >= n_ext) ? (s_q - n_ext) : s_q);
  end

  assign ready = ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/rsa_4k.sv
// RSA engine: cypher = message^exponent mod modulus via Montgomery-domain
// left-to-right square-and-always-multiply with a fixed, data-independent latency.
module rsa_4k
  import rsa_4k_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] cypher,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] cypher_q, cypher_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             kick_q, kick_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   a2, b2, nx;
  logic             mm_start, mm_ready;
  logic [WIDTH-1:0] mm_x, mm_y, mm_result;

  rsa_4k_montmul #(.WIDTH(WIDTH)) u_montmul (
    .clk    (clk),
    .reset  (reset),
    .start  (mm_start),
    .x      (mm_x),
    .y      (mm_y),
    .n      (n_q),
    .result (mm_result),
    .ready  (mm_ready)
  );

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cypher_d = cypher_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    kick_d   = 1'b0;
    done_d   = done_q;
    mm_start = 1'b0;
    mm_x     = acc_q;
    mm_y     = acc_q;
    nx       = {1'b0, n_q};
    a2       = {a_q, 1'b0};
    b2       = {b_q, 1'b0};

    unique case (state_q)
      IDLE: begin
        if (go) begin
          exp_d   = exponent;
          n_d     = modulus;
          a_d     = WIDTH'(1);
          b_d     = message;
          cnt_d   = '0;
          state_d = PRE;
        end
      end
      // a converges to R mod N and b to message*R mod N by repeated doubling.
      PRE: begin
        a_d   = WIDTH'((a2 >= nx) ? (a2 - nx) : a2);
        b_d   = WIDTH'((b2 >= nx) ? (b2 - nx) : b2);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          acc_d   = a_d;
          cnt_d   = CW'(WIDTH - 1);
          phase_d = 1'b0;
          kick_d  = 1'b1;
          state_d = EXP;
        end
      end
      // Each finished multiply immediately launches the next one on the same edge.
      EXP: begin
        if (kick_q) begin
          mm_start = 1'b1;
        end else if (mm_ready) begin
          mm_start = 1'b1;
          if (!phase_q) begin
            acc_d   = mm_result;
            mm_x    = acc_d;
            mm_y    = b_q;
            phase_d = 1'b1;
          end else begin
            if (exp_q[cnt_q]) begin
              acc_d = mm_result;
            end
            phase_d = 1'b0;
            mm_x    = acc_d;
            if (cnt_q == '0) begin
              mm_y    = WIDTH'(1);
              state_d = POST;
            end else begin
              mm_y  = acc_d;
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
      end
      POST: begin
        if (mm_ready) begin
          cypher_d = mm_result;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase
  end

  assign cypher = cypher_q;
  assign done   = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cypher_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      kick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cypher_q <= cypher_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      kick_q   <= kick_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_rsa_4k.sv
// Self-checking bench for rsa_4k at WIDTH=16: results against a plain
// square-and-multiply model, plus exact latency, hold, abort and input-change checks.
module tb_rsa_4k;

  localparam int W   = 16;
  localparam int LAT = W + 2 * W * (W + 1) + (W + 1) + 1;

  logic         clk;
  logic         reset;
  logic         go;
  logic [W-1:0] message;
  logic [W-1:0] exponent;
  logic [W-1:0] modulus;
  logic [W-1:0] cypher;
  logic         done;

  int total;
  int bad;

  rsa_4k #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .message  (message),
    .exponent (exponent),
    .modulus  (modulus),
    .cypher   (cypher),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Right-to-left square-and-multiply on plain integers.
  function automatic logic [W-1:0] ref_modexp(input longint unsigned m,
                                               input longint unsigned e,
                                               input longint unsigned n);
    longint unsigned r;
    longint unsigned b;
    longint unsigned k;
    r = 1 % n;
    b = m % n;
    k = e;
    while (k != 0) begin
      if (k[0]) r = (r * b) % n;
      b = (b * b) % n;
      k = k >> 1;
    end
    return W'(r);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    go    = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts a job and counts edges after the capture edge until done is seen.
  task automatic run_job(input logic [W-1:0] m, input logic [W-1:0] e,
                         input logic [W-1:0] n, input bit hold_go,
                         input bit scramble, output int cycles);
    @(negedge clk);
    message  = m;
    exponent = e;
    modulus  = n;
    go       = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_go) go = 1'b0;
    cycles = -1;
    for (int c = 1; c <= 2 * LAT; c++) begin
      @(posedge clk);
      #1;
      if (scramble) begin
        message  = W'($urandom);
        exponent = W'($urandom);
        modulus  = W'($urandom);
      end
      if (done) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_done got=%0b want=0", done);
    end
    total++;
    if (cypher !== '0) begin
      bad++;
      $display("[TB] FAIL reset_cypher got=%0d want=0", cypher);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_no_go got=%0b want=0", done);
    end
  endtask

  task automatic test_known_vectors();
    int cyc;
    do_reset();
    run_job(16'd8, 16'd13, 16'd77, 1'b1, 1'b0, cyc);
    total++;
    if (cyc != LAT) begin
      bad++;
      $display("[TB] FAIL enc_latency got=%0d want=%0d", cyc, LAT);
    end
    total++;
    if (cypher !== 16'd50) begin
      bad++;
      $display("[TB] FAIL enc_8_13_77 got=%0d want=50", cypher);
    end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b1 || cypher !== 16'd50) begin
      bad++;
      $display("[TB] FAIL done_hold got=%0b/%0d want=1/50", done, cypher);
    end
    go = 1'b0;
    do_reset();
    run_job(16'd50, 16'd37, 16'd77, 1'b0, 1'b0, cyc);
    total++;
    if (cyc != LAT || cypher !== 16'd8) begin
      bad++;
      $display("[TB] FAIL dec_50_37_77 got=%0d (lat %0d) want=8 (lat %0d)", cypher, cyc, LAT);
    end
  endtask

  task automatic test_edge_cases();
    int cyc;
    logic [W-1:0] e;
    do_reset();
    run_job(16'd5, 16'd0, 16'd77, 1'b0, 1'b0, cyc);
    total++;
    if (cyc != LAT || cypher !== 16'd1) begin
      bad++;
      $display("[TB] FAIL exp_zero got=%0d (lat %0d) want=1", cypher, cyc);
    end
    do_reset();
    run_job(16'd0, 16'd3, 16'd77, 1'b0, 1'b0, cyc);
    total++;
    if (cyc != LAT || cypher !== 16'd0) begin
      bad++;
      $display("[TB] FAIL msg_zero got=%0d (lat %0d) want=0", cypher, cyc);
    end
    e = W'($urandom);
    do_reset();
    run_job(16'd1, e, 16'd65535, 1'b0, 1'b0, cyc);
    total++;
    if (cyc != LAT || cypher !== 16'd1) begin
      bad++;
      $display("[TB] FAIL msg_one e=%0d got=%0d want=1", e, cypher);
    end
    do_reset();
    run_job(16'd65534, 16'd65535, 16'd65535, 1'b0, 1'b0, cyc);
    total++;
    if (cyc != LAT || cypher !== ref_modexp(65534, 65535, 65535)) begin
      bad++;
      $display("[TB] FAIL max_operands got=%0d want=%0d", cypher, ref_modexp(65534, 65535, 65535));
    end
  endtask

  task automatic test_abort();
    int cyc;
    do_reset();
    @(negedge clk);
    message  = 16'd8;
    exponent = 16'd13;
    modulus  = 16'd77;
    go       = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (LAT / 2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || cypher !== '0) begin
      bad++;
      $display("[TB] FAIL abort_clear got=%0b/%0d want=0/0", done, cypher);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 5) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_idle got=%0b want=0", done);
    end
    run_job(16'd8, 16'd13, 16'd77, 1'b0, 1'b0, cyc);
    total++;
    if (cyc != LAT || cypher !== 16'd50) begin
      bad++;
      $display("[TB] FAIL abort_rerun got=%0d (lat %0d) want=50 (lat %0d)", cypher, cyc, LAT);
    end
  endtask

  task automatic test_input_change();
    int cyc;
    logic [W-1:0] n, m, e;
    for (int k = 0; k < 3; k++) begin
      n = W'($urandom_range(3, 65535)) | 16'd1;
      m = W'($urandom_range(0, int'(n) - 1));
      e = W'($urandom);
      do_reset();
      run_job(m, e, n, 1'b1, 1'b1, cyc);
      total++;
      if (cyc != LAT || cypher !== ref_modexp(m, e, n)) begin
        bad++;
        $display("[TB] FAIL input_change m=%0d e=%0d n=%0d got=%0d (lat %0d) want=%0d (lat %0d)",
                 m, e, n, cypher, cyc, ref_modexp(m, e, n), LAT);
      end
      go = 1'b0;
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [W-1:0] n, m, e;
    for (int k = 0; k < 20; k++) begin
      n = W'($urandom_range(3, 65535)) | 16'd1;
      m = W'($urandom_range(0, int'(n) - 1));
      e = W'($urandom);
      do_reset();
      run_job(m, e, n, 1'b0, 1'b0, cyc);
      total++;
      if (cyc != LAT || cypher !== ref_modexp(m, e, n)) begin
        bad++;
        $display("[TB] FAIL random m=%0d e=%0d n=%0d got=%0d (lat %0d) want=%0d (lat %0d)",
                 m, e, n, cypher, cyc, ref_modexp(m, e, n), LAT);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    go       = 1'b0;
    message  = '0;
    exponent = '0;
    modulus  = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_known_vectors();
    test_edge_cases();
    test_abort();
    test_input_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
